// File: rtl/ysyx_22050518_mul_ctrl.sv
// Issue/response controller between the EX-stage RV64M dispatch and the
// 8-cycle multiplier: decodes the op, launches it, picks hi/lo and returns it.
module ysyx_22050518_mul_ctrl #(
  parameter int WATCHDOG = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy,
  output logic        err,
  output logic        m_valid,
  output logic        m_flush,
  output logic        m_mulw,
  output logic [1:0]  m_signed,
  output logic [63:0] m_multiplicand,
  output logic [63:0] m_multiplier,
  input  logic        m_out_ready,
  input  logic        m_out_valid,
  input  logic [63:0] m_result_hi,
  input  logic [63:0] m_result_lo
);

  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(WATCHDOG + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   src1_q;
  logic [DATA_W-1:0]   src2_q;
  logic [4:0]          rd_q;
  logic                mulw_q;
  logic [1:0]          signed_q;
  logic [CNT_W-1:0]    cnt;
  logic                timeout;
  logic                abort;

  function automatic logic op_illegal(input logic [2:0] op);
    return op[2] & (|op[1:0]);
  endfunction

  // mul_signed[1] qualifies the multiplicand, [0] the multiplier.
  function automatic logic [1:0] dec_signed(input logic [2:0] op);
    logic [1:0] s;
    case (op)
      OP_MULHSU: s = 2'b10;
      OP_MULHU:  s = 2'b00;
      default:   s = 2'b11;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] select_result(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] hi,
    input logic [DATA_W-1:0] lo
  );
    logic [DATA_W-1:0] r;
    case (op)
      OP_MUL:                      r = lo;
      OP_MULH, OP_MULHSU, OP_MULHU: r = hi;
      OP_MULW:                     r = {{32{lo[31]}}, lo[31:0]};
      default:                     r = '0;
    endcase
    return r;
  endfunction

  assign timeout = (cnt == CNT_W'(WATCHDOG - 1));
  // A flush takes precedence over the watchdog, so a flushed op never reports err.
  assign abort   = (state == WAIT) && !flush && !m_out_valid && timeout;

  assign req_ready      = (state == IDLE) && !flush;
  assign busy           = (state != IDLE);
  assign err            = abort;
  assign m_valid        = (state == ISSUE) && !flush;
  assign m_flush        = flush | abort;
  assign m_mulw         = mulw_q;
  assign m_signed       = signed_q;
  assign m_multiplicand = src1_q;
  assign m_multiplier   = src2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      rd_q       <= '0;
      mulw_q     <= 1'b0;
      signed_q   <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            src1_q   <= req_src1;
            src2_q   <= req_src2;
            rd_q     <= req_rd;
            mulw_q   <= (req_op == OP_MULW);
            signed_q <= dec_signed(req_op);
            if (op_illegal(req_op)) begin
              // Illegal ops bypass the multiplier and answer zero.
              resp_data  <= '0;
              resp_rd    <= req_rd;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (m_out_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (m_out_valid) begin
            resp_data  <= select_result(op_q, m_result_hi, m_result_lo);
            resp_rd    <= rd_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050518_mul_ctrl.sv
// Directed and randomized bench for ysyx_22050518_mul_ctrl with a behavioural
// 8-cycle multiplier and an arithmetic reference for every RV64M op.
module tb_ysyx_22050518_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;
  logic        err;
  logic        m_valid;
  logic        m_flush;
  logic        m_mulw;
  logic [1:0]  m_signed;
  logic [63:0] m_multiplicand;
  logic [63:0] m_multiplier;
  logic        m_out_ready;
  logic        m_out_valid;
  logic [63:0] m_result_hi;
  logic [63:0] m_result_lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic stuck;

  always #5 clk = ~clk;

  ysyx_22050518_mul_ctrl #(.WATCHDOG(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .busy(busy), .err(err),
    .m_valid(m_valid), .m_flush(m_flush), .m_mulw(m_mulw), .m_signed(m_signed),
    .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier),
    .m_out_ready(m_out_ready), .m_out_valid(m_out_valid),
    .m_result_hi(m_result_hi), .m_result_lo(m_result_lo)
  );

  // Multiplier model: accepts when idle, strobes the 128-bit product 8 cycles later.
  function automatic logic [127:0] mprod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] sg);
    logic [127:0] ea, eb;
    ea = sg[1] ? {{64{a[63]}}, a} : {64'b0, a};
    eb = sg[0] ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  int           mcnt;
  logic [127:0] mp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0; mp <= '0;
      m_out_ready <= 1'b1; m_out_valid <= 1'b0;
      m_result_hi <= '0; m_result_lo <= '0;
    end else if (m_flush) begin
      mcnt <= 0; m_out_ready <= 1'b1; m_out_valid <= 1'b0;
    end else begin
      m_out_valid <= 1'b0;
      if (m_out_valid) m_out_ready <= 1'b1;
      if (m_valid && m_out_ready && !stuck) begin
        mcnt <= 7;
        m_out_ready <= 1'b0;
        mp <= mprod(m_multiplicand, m_multiplier, m_signed);
      end else if (mcnt == 1) begin
        mcnt <= 0;
        m_out_valid <= 1'b1;
        m_result_hi <= mp[127:64];
        m_result_lo <= mp[63:0];
      end else if (mcnt > 1) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Reference result straight from the RV64M definitions.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] sa, sb, za, zb, p;
    sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
    za = {64'b0, a};       zb = {64'b0, b};
    case (op)
      3'd0: begin p = za * zb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * zb; return p[127:64]; end
      3'd3: begin p = za * zb; return p[127:64]; end
      3'd4: begin p = za * zb; return {{32{p[31]}}, p[31:0]}; end
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from IDLE; hold = cycles the consumer stalls in RESP.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input int hold);
    logic [63:0] exp_d;
    logic        legal;
    int          n;
    exp_d = ref_result(op, a, b);
    legal = (op <= 3'd4);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_rd = rd;
    resp_ready = (hold == 0);
    tick();
    req_valid = 1'b0;
    req_src1 = {$urandom, $urandom}; req_src2 = {$urandom, $urandom}; req_rd = 5'($urandom);
    chk("m_valid_issue", 64'(m_valid), 64'(legal));
    if (legal) begin
      chk("m_mulw", 64'(m_mulw), 64'(op == 3'd4));
      chk("m_signed", 64'(m_signed), (op == 3'd2) ? 64'd2 : (op == 3'd3) ? 64'd0 : 64'd3);
      chk("m_multiplicand", m_multiplicand, a);
      chk("m_multiplier", m_multiplier, b);
    end
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
      if (n == 5) chk("operands_stable_wait", m_multiplicand ^ m_multiplier, a ^ b);
    end
    chk("latency", 64'(n), legal ? 64'd9 : 64'd0);
    chk("resp_data", resp_data, exp_d);
    chk("resp_rd", 64'(resp_rd), 64'(rd));
    repeat (hold) begin
      tick();
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", resp_data, exp_d);
      chk("hold_rd", 64'(resp_rd), 64'(rd));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    chk("resp_single_pulse", 64'(resp_valid), 64'd0);
    chk("idle_after_resp", 64'(busy), 64'd0);
  endtask

  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = a; req_src2 = b; req_rd = 5'd1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;
    logic [2:0] op;
    logic [63:0] a, b;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_src1 = '0; req_src2 = '0; req_rd = '0; resp_ready = 1'b0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_rd", 64'(resp_rd), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_operand", m_multiplicand, 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(3'd0, 64'd3, 64'd5, 5'd7, 0);
    run_op(3'd1, '1, '1, 5'd1, 0);
    run_op(3'd3, '1, 64'd2, 5'd2, 0);
    run_op(3'd2, '1, 64'd2, 5'd3, 0);
    run_op(3'd4, 64'h7FFF_FFFF, 64'd2, 5'd4, 0);
    run_op(3'd4, 64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002, 5'd5, 0);
    chk("mulw_value", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd0, 64'd11, 64'd13, 5'd9, 5);

    // Flush in the fourth WAIT cycle.
    launch(64'd100, 64'd3);
    repeat (4) tick();
    flush = 1'b1;
    #1;
    chk("flush_m_flush", 64'(m_flush), 64'd1);
    chk("flush_no_err", 64'(err), 64'd0);
    chk("flush_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (12) begin tick(); seen |= resp_valid; end
    chk("flush_no_resp", 64'(seen), 64'd0);
    run_op(3'd0, 64'd6, 64'd7, 5'd3, 0);
    chk("after_flush_42", resp_data, 64'd42);

    // Flush with a request pending in IDLE.
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0;
    #1;
    chk("flush_idle_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_not_accepted", 64'(busy), 64'd0);

    // Flush coinciding with the result strobe.
    launch(64'd9, 64'd9);
    n = 0;
    while (!m_out_valid && n < 40) begin tick(); n++; end
    chk("strobe_seen", 64'(m_out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_strobe_discard", 64'(resp_valid), 64'd0);
    chk("flush_strobe_idle", 64'(busy), 64'd0);
    tick();

    // Stuck multiplier: watchdog abort.
    stuck = 1'b1;
    launch(64'd2, 64'd2);
    n = 1;
    while (!err && n < 40) begin tick(); n++; end
    chk("wd_cycle", 64'(n), 64'd17);
    chk("wd_m_flush", 64'(m_flush), 64'd1);
    tick();
    chk("wd_idle", 64'(busy), 64'd0);
    chk("wd_err_pulse", 64'(err), 64'd0);
    chk("wd_no_resp", 64'(resp_valid), 64'd0);
    stuck = 1'b0;
    tick();

    run_op(3'd5, 64'd4, 64'd4, 5'd10, 0);
    run_op(3'd7, '1, '1, 5'd11, 1);

    // Asynchronous reset mid-operation.
    launch(64'd77, 64'd5);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_operand", m_multiplicand, 64'd0);
    chk("async_rst_m_valid", 64'(m_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 9) > 7 ? 0 : $urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 6 == 0) a = '1;
      if (i % 7 == 0) b = 64'h8000_0000_0000_0000;
      run_op(op, a, b, 5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
